// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// The scanner FSM alternates a blanking phase and a drive phase inside every digit slot.
package seven_seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    // Active-low cathode pattern with every segment dark.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low anode pattern that enables exactly one digit.
    function automatic logic [31:0] anode_select(input int unsigned idx);
        anode_select = ~(32'd1 << idx);
    endfunction

endpackage

// File: rtl/seven_seg_bto7s.sv
// Hex nibble to seven-segment decoder, active-high segments.
// Bit 0 is segment a through bit 6 for segment g.
module bto7s (
    input  logic [3:0] x_in,
    output logic [6:0] s_out
);

    always_comb begin
        s_out = 7'h00;
        case (x_in)
            4'h0: s_out = 7'h3F;
            4'h1: s_out = 7'h06;
            4'h2: s_out = 7'h5B;
            4'h3: s_out = 7'h4F;
            4'h4: s_out = 7'h66;
            4'h5: s_out = 7'h6D;
            4'h6: s_out = 7'h7D;
            4'h7: s_out = 7'h07;
            4'h8: s_out = 7'h7F;
            4'h9: s_out = 7'h6F;
            4'hA: s_out = 7'h77;
            4'hB: s_out = 7'h7C;
            4'hC: s_out = 7'h39;
            4'hD: s_out = 7'h5E;
            4'hE: s_out = 7'h79;
            4'hF: s_out = 7'h71;
            default: s_out = 7'h00;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexes a double-buffered hex value across common-anode digits,
// swapping in new values only at frame boundaries and blanking between digits.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int COUNT_PERIOD = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [4*NUM_DIGITS-1:0] val_in,
    input  logic                    val_valid_in,
    output logic                    val_ready_out,
    input  logic                    blank_lz_in,
    output logic [6:0]              cat_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done_out
);

    localparam int CW = $clog2(COUNT_PERIOD);
    localparam int DW = $clog2(NUM_DIGITS);
    localparam int VW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] CNT_LAST   = CW'(COUNT_PERIOD - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

    scan_state_t           state, state_next;
    logic [CW-1:0]         cnt, cnt_next;
    logic [DW-1:0]         digit_idx, digit_next;
    logic                  slot_end;
    logic                  wrap;

    logic [VW-1:0]         active;
    logic [VW-1:0]         pending;
    logic                  pending_full;
    logic                  accept;

    logic [3:0]            nibble;
    logic [6:0]            seg_raw;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  upper_zero;

    logic [NUM_DIGITS-1:0] an_next;
    logic [6:0]            cat_next;
    logic                  frame_done_next;

    // Slot timing: the counter runs across the whole slot, BLANK covers the first
    // BLANK_CYCLES counts and DRIVE the rest; phases change on their last cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + CW'(1);
        digit_next = digit_idx;
        slot_end   = 1'b0;
        case (state)
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt == CNT_LAST) begin
                    state_next = BLANK;
                    cnt_next   = '0;
                    slot_end   = 1'b1;
                    digit_next = (digit_idx == DIGIT_LAST) ? '0 : digit_idx + DW'(1);
                end
            end
            default: begin
                state_next = BLANK;
                cnt_next   = '0;
                digit_next = '0;
            end
        endcase
    end

    assign wrap = slot_end && (digit_idx == DIGIT_LAST);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= BLANK;
            cnt       <= '0;
            digit_idx <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            digit_idx <= digit_next;
        end
    end

    // Load port: a transfer happens on a clock edge where val_valid_in && val_ready_out;
    // ready is the registered inverse of pending_full, and upstream holds the data until taken.
    assign accept = val_valid_in && val_ready_out;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            active        <= '0;
            pending       <= '0;
            pending_full  <= 1'b0;
            val_ready_out <= 1'b1;
        end else begin
            if (accept) begin
                pending       <= val_in;
                pending_full  <= 1'b1;
                val_ready_out <= 1'b0;
            end else if (wrap && pending_full) begin
                active        <= pending;
                pending_full  <= 1'b0;
                val_ready_out <= 1'b1;
            end
        end
    end

    always_comb begin
        nibble = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_idx == DW'(k)) begin
                nibble = active[4*k +: 4];
            end
        end
    end

    // A digit above 0 is a leading zero when it and every higher nibble are zero.
    always_comb begin
        lz_mask    = '0;
        upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            upper_zero = upper_zero && (active[4*k +: 4] == 4'h0);
            lz_mask[k] = upper_zero;
        end
    end

    bto7s u_bto7s (
        .x_in  (nibble),
        .s_out (seg_raw)
    );

    // Outputs are registered from the next-state view so pins move on the FSM edge.
    // The digit never changes on entry to DRIVE, so digit_idx addresses the decoder.
    always_comb begin
        an_next         = '1;
        cat_next        = SEG_OFF;
        frame_done_next = (cnt_next == CNT_LAST) && (digit_next == DIGIT_LAST);
        if (state_next == DRIVE) begin
            an_next = anode_select(32'(digit_next))[NUM_DIGITS-1:0];
            if (!(blank_lz_in && lz_mask[digit_next])) begin
                cat_next = ~seg_raw;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            an_out         <= '1;
            cat_out        <= SEG_OFF;
            frame_done_out <= 1'b0;
        end else begin
            an_out         <= an_next;
            cat_out        <= cat_next;
            frame_done_out <= frame_done_next;
        end
    end

    a_one_anode: assert property (@(posedge clk_in) disable iff (!rst_n_in)
        $countones(~an_out) <= 1);

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with 8 digits, 8-cycle slots, 2 blank cycles.
// Cycle c counts rising edges since reset release; a frame is 64 cycles.
module tb_seven_seg_scanner;

    logic        clk;
    logic        rst_n;
    logic [31:0] val;
    logic        valid;
    logic        ready;
    logic        blank_lz;
    logic [6:0]  cat;
    logic [7:0]  an;
    logic        frame_done;

    int n_vec = 0;
    int n_err = 0;
    int cyc;

    seven_seg_scanner #(
        .NUM_DIGITS   (8),
        .COUNT_PERIOD (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .val_in         (val),
        .val_valid_in   (valid),
        .val_ready_out  (ready),
        .blank_lz_in    (blank_lz),
        .cat_out        (cat),
        .an_out         (an),
        .frame_done_out (frame_done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic goto_cycle(input int c);
        if (cyc > c) check("sequence", cyc, c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_disp(input int c, input logic [7:0] an_exp, input logic [6:0] cat_exp);
        goto_cycle(c);
        check($sformatf("an@%0d", c), an, an_exp);
        check($sformatf("cat@%0d", c), cat, cat_exp);
    endtask

    // Presents v and holds it until taken; acc is the cycle whose closing edge accepted it.
    task automatic load(input logic [31:0] v, output int acc);
        acc   = -1;
        val   = v;
        valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (ready) begin
                acc = cyc;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        valid = 1'b0;
    endtask

    initial begin
        int acc;
        int pulses;
        logic [7:0] an_exp;

        rst_n    = 1'b0;
        val      = '0;
        valid    = 1'b0;
        blank_lz = 1'b0;

        // 1: reset values, then first slot timing
        repeat (3) @(negedge clk);
        check("rst_an", an, 8'hFF);
        check("rst_cat", cat, 7'h7F);
        check("rst_ready", ready, 1'b1);
        check("rst_fd", frame_done, 1'b0);
        rst_n = 1'b1;
        check_disp(1, 8'hFF, 7'h7F);
        check_disp(2, 8'hFE, 7'h40);
        check_disp(7, 8'hFE, 7'h40);
        check_disp(8, 8'hFF, 7'h7F);

        // 2: load mid-frame, shown only after the frame boundary
        goto_cycle(20);
        check("ready@20", ready, 1'b1);
        load(32'h1234ABCD, acc);
        check("acc1", acc, 20);
        check("ready@21", ready, 1'b0);
        check_disp(26, 8'hF7, 7'h40);
        goto_cycle(62);
        check("fd@62", frame_done, 1'b0);
        goto_cycle(63);
        check("fd@63", frame_done, 1'b1);
        check("ready@63", ready, 1'b0);
        goto_cycle(64);
        check("fd@64", frame_done, 1'b0);
        check("ready@64", ready, 1'b1);
        check_disp(66, 8'hFE, 7'h21);
        check_disp(74, 8'hFD, 7'h46);
        check_disp(98, 8'hEF, 7'h19);

        // 3: back-to-back loads; the second waits for the boundary
        goto_cycle(100);
        load(32'h87654321, acc);
        check("acc2", acc, 100);
        load(32'hFEDCBA90, acc);
        check("acc3", acc, 128);
        check("ready@129", ready, 1'b0);
        check_disp(130, 8'hFE, 7'h79);
        check_disp(186, 8'h7F, 7'h00);
        check_disp(194, 8'hFE, 7'h40);
        check_disp(202, 8'hFD, 7'h10);

        // 4: leading-zero blanking
        goto_cycle(204);
        blank_lz = 1'b1;
        load(32'h000000A5, acc);
        check("acc4", acc, 204);
        check_disp(258, 8'hFE, 7'h12);
        check_disp(266, 8'hFD, 7'h08);
        goto_cycle(270);
        load(32'h00000000, acc);
        check("acc5", acc, 270);
        check_disp(274, 8'hFB, 7'h7F);
        check_disp(314, 8'h7F, 7'h7F);
        check_disp(322, 8'hFE, 7'h40);
        check_disp(330, 8'hFD, 7'h7F);

        // 5: async reset during DRIVE of digit 3 with pending full
        goto_cycle(340);
        load(32'h11111111, acc);
        check("acc6", acc, 340);
        check_disp(347, 8'hF7, 7'h7F);
        check("ready@347", ready, 1'b0);
        blank_lz = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("arst_an", an, 8'hFF);
        check("arst_cat", cat, 7'h7F);
        check("arst_ready", ready, 1'b1);
        check("arst_fd", frame_done, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        goto_cycle(1);
        check("ready_post", ready, 1'b1);
        check_disp(2, 8'hFE, 7'h40);
        check_disp(10, 8'hFD, 7'h40);
        check_disp(66, 8'hFE, 7'h40);

        // 6: free-run three frames
        pulses = 0;
        for (int c = 128; c < 320; c++) begin
            goto_cycle(c);
            an_exp = 8'hFF;
            if ((c % 8) >= 2) an_exp = ~(8'd1 << ((c / 8) % 8));
            check($sformatf("run_an@%0d", c), an, an_exp);
            check($sformatf("run_fd@%0d", c), frame_done, ((c % 64) == 63) ? 1'b1 : 1'b0);
            if (frame_done) pulses++;
        end
        check("fd_pulses", pulses, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
